// File: rtl/icu_pkg.sv
// Shared constants for the interrupt control unit: register map, CTRL bit positions, line count.
package icu_pkg;

    localparam int NUM_IRQ = 8;

    localparam logic [1:0] ICU_ADDR_BASE = 2'b00;
    localparam logic [1:0] ICU_ADDR_EOI  = 2'b01;
    localparam logic [1:0] ICU_ADDR_IMR  = 2'b10;
    localparam logic [1:0] ICU_ADDR_CTRL = 2'b11;

    localparam int CTRL_GEN_BIT     = 0;
    localparam int CTRL_AEOI_BIT    = 1;
    localparam int EOI_SPECIFIC_BIT = 7;

endpackage

// File: rtl/icu_prio_enc.sv
// Fixed-priority encoder: reports the lowest set index of an 8-bit vector.
// Latency: combinational, 0 cycles.
// Backpressure: none, pure function of its input.
module icu_prio_enc
    import icu_pkg::*;
(
    input  logic [NUM_IRQ-1:0] req,
    output logic               valid,
    output logic [2:0]         idx
);

    // Scan high to low so the lowest set bit is the last to be written.
    always_comb begin
        idx = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/interrupt_control_unit.sv
// 8-line vectored interrupt controller with IRR/IMR/ISR, fixed priority, optional debug taps (ICU_DEBUG_PORTS_EN).
// Latency: request to o_intr in 2 cycles; acknowledge edge to o_vector in 1 cycle.
// Backpressure: none; requests stay latched in IRR until acknowledged.
module interrupt_control_unit
    import icu_pkg::*;
#(
    parameter logic [7:0] RESET_BASE = 8'h00
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_IRQ-1:0] i_interrupt,
    input  logic [1:0]         i_addr,
    input  logic               i_we,
    input  logic               i_cs,
    input  logic [7:0]         i_data,
    input  logic               i_inta,
    output logic               o_intr,
    output logic [7:0]         o_vector
`ifdef ICU_DEBUG_PORTS_EN
    ,
    output logic [7:0]         o_dbg_irr,
    output logic [7:0]         o_dbg_isr,
    output logic [7:0]         o_dbg_imr,
    output logic [7:0]         o_dbg_ctrl
`endif
);

    logic [NUM_IRQ-1:0] irr;
    logic [NUM_IRQ-1:0] isr;
    logic [NUM_IRQ-1:0] imr;
    logic [4:0]         base;
    logic [1:0]         ctrl;
    logic               inta_q;

    logic               strobe;
    logic               ack;
    logic [NUM_IRQ-1:0] pend;
    logic               pend_vld;
    logic [2:0]         sel;
    logic               isr_vld;
    logic [2:0]         cur;
    logic               sel_wins;
    logic [NUM_IRQ-1:0] ack_clear;
    logic [NUM_IRQ-1:0] isr_set;
    logic [NUM_IRQ-1:0] eoi_clear;

    assign strobe = i_cs & i_we;
    assign pend   = irr & imr;

    icu_prio_enc u_pend_enc (
        .req   (pend),
        .valid (pend_vld),
        .idx   (sel)
    );

    icu_prio_enc u_isr_enc (
        .req   (isr),
        .valid (isr_vld),
        .idx   (cur)
    );

    // An empty ISR behaves as level 8, below every real line.
    assign sel_wins  = pend_vld & (~isr_vld | (sel < cur));
    assign ack       = i_inta & ~inta_q & o_intr;
    assign ack_clear = ack ? (8'd1 << sel) : 8'd0;
    assign isr_set   = ctrl[CTRL_AEOI_BIT] ? 8'd0 : ack_clear;

    always_comb begin
        eoi_clear = 8'd0;
        if (strobe && (i_addr == ICU_ADDR_EOI)) begin
            if (i_data[EOI_SPECIFIC_BIT]) begin
                eoi_clear = 8'd1 << i_data[2:0];
            end else if (isr_vld) begin
                eoi_clear = 8'd1 << cur;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            irr      <= '0;
            isr      <= '0;
            imr      <= '0;
            base     <= RESET_BASE[7:3];
            ctrl     <= 2'b00;
            inta_q   <= 1'b0;
            o_intr   <= 1'b0;
            o_vector <= 8'h00;
        end else begin
            // A line still high re-latches over its own acknowledge clear.
            irr    <= (irr & ~ack_clear) | i_interrupt;
            isr    <= (isr & ~eoi_clear) | isr_set;
            inta_q <= i_inta;
            o_intr <= ctrl[CTRL_GEN_BIT] & sel_wins & ~ack;
            if (ack) begin
                o_vector <= {base, sel};
            end
            if (strobe) begin
                case (i_addr)
                    ICU_ADDR_BASE: base <= i_data[7:3];
                    ICU_ADDR_IMR:  imr  <= i_data;
                    ICU_ADDR_CTRL: ctrl <= i_data[1:0];
                    default:       ;
                endcase
            end
        end
    end

`ifdef ICU_DEBUG_PORTS_EN
    assign o_dbg_irr  = irr;
    assign o_dbg_isr  = isr;
    assign o_dbg_imr  = imr;
    assign o_dbg_ctrl = {6'b000000, ctrl};
`endif

endmodule

// File: tb/tb_interrupt_control_unit.sv
// Directed scenarios plus random traffic for interrupt_control_unit, checked against a register-level reference model.
module tb_interrupt_control_unit;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b1;
    logic [7:0] i_interrupt = 8'h00;
    logic [1:0] i_addr = 2'b00;
    logic       i_we = 1'b0;
    logic       i_cs = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_inta = 1'b0;
    logic       o_intr;
    logic [7:0] o_vector;

    always #5 i_clk = ~i_clk;

    interrupt_control_unit dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_interrupt (i_interrupt),
        .i_addr      (i_addr),
        .i_we        (i_we),
        .i_cs        (i_cs),
        .i_data      (i_data),
        .i_inta      (i_inta),
        .o_intr      (o_intr),
        .o_vector    (o_vector)
    );

    // Reference model state
    logic [7:0] m_irr, m_isr, m_imr, m_base, m_ctrl, m_vec;
    logic       m_intr, m_inta_q;

    int errors = 0;
    int checks = 0;

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            if (v[i]) return i;
        end
        return 8;
    endfunction

    task automatic model_reset();
        m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'h00; m_ctrl = 8'h00;
        m_base = 8'h00; m_vec = 8'h00; m_intr = 1'b0; m_inta_q = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int         sel;
        int         cur;
        logic       strobe;
        logic       ack;
        logic [7:0] isr_n;
        logic [7:0] irr_n;
        strobe = i_cs && i_we;
        ack    = i_inta && !m_inta_q && m_intr;
        sel    = lowest(m_irr & m_imr);
        cur    = lowest(m_isr);
        isr_n  = m_isr;
        irr_n  = m_irr;
        if (strobe && i_addr == 2'd1) begin
            if (i_data[7]) isr_n[i_data[2:0]] = 1'b0;
            else if (cur < 8) isr_n[cur] = 1'b0;
        end
        if (ack) begin
            m_vec = {m_base[7:3], 3'(sel)};
            irr_n[sel] = 1'b0;
            if (!m_ctrl[1]) isr_n[sel] = 1'b1;
        end
        m_intr = m_ctrl[0] && (sel < cur) && !ack;
        m_irr  = irr_n | i_interrupt;
        m_isr  = isr_n;
        if (strobe) begin
            case (i_addr)
                2'd0: m_base = i_data;
                2'd2: m_imr  = i_data;
                2'd3: m_ctrl = i_data;
                default: ;
            endcase
        end
        m_inta_q = i_inta;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge i_clk);
        #1;
        check("o_intr", {7'd0, o_intr}, {7'd0, m_intr});
        check("o_vector", o_vector, m_vec);
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        i_cs = 1'b1; i_we = 1'b1; i_addr = a; i_data = d;
        tick();
        i_cs = 1'b0; i_we = 1'b0;
    endtask

    // Asserts reset mid-cycle and checks outputs clear without waiting for a clock.
    task automatic do_reset();
        i_inta = 1'b0; i_cs = 1'b0; i_we = 1'b0;
        i_rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_intr", {7'd0, o_intr}, 8'h00);
        check("rst_vector", o_vector, 8'h00);
        @(posedge i_clk);
        @(posedge i_clk);
        #1 i_rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #2;
        do_reset();

        // Request with everything masked/disabled stays silent.
        i_interrupt = 8'h01;
        tick(); tick(); tick();
        check("masked_intr", {7'd0, o_intr}, 8'h00);
        wr(2'd2, 8'h55);
        wr(2'd3, 8'h01);
        tick();
        check("enable_intr", {7'd0, o_intr}, 8'h01);

        // Acknowledge line 0; held line re-latches but is blocked by ISR[0].
        i_inta = 1'b1;
        tick();
        check("ack0_vector", o_vector, 8'h00);
        check("ack0_intr", {7'd0, o_intr}, 8'h00);
        tick();
        i_inta = 1'b0;
        tick(); tick();
        check("inservice0_intr", {7'd0, o_intr}, 8'h00);
        wr(2'd1, 8'h80);
        tick();
        check("relatch_intr", {7'd0, o_intr}, 8'h01);

        // Base A0, lines 3 and 5.
        i_interrupt = 8'h00;
        do_reset();
        wr(2'd0, 8'hA0);
        wr(2'd2, 8'hFF);
        wr(2'd3, 8'h01);
        i_interrupt = 8'h28;
        tick(); tick();
        check("irq3_intr", {7'd0, o_intr}, 8'h01);
        i_inta = 1'b1; i_interrupt = 8'h20;
        tick();
        check("ack3_vector", o_vector, 8'hA3);
        i_inta = 1'b0;
        tick(); tick(); tick();
        check("blocked5_intr", {7'd0, o_intr}, 8'h00);
        wr(2'd1, 8'h00);
        tick();
        check("eoi3_intr", {7'd0, o_intr}, 8'h01);
        i_inta = 1'b1;
        tick();
        check("ack5_vector", o_vector, 8'hA5);
        i_inta = 1'b0; i_interrupt = 8'h00;
        tick();

        // Nesting: line 1 preempts line 4 in service.
        do_reset();
        wr(2'd2, 8'hFF);
        wr(2'd3, 8'h01);
        i_interrupt = 8'h10;
        tick(); tick();
        i_inta = 1'b1; i_interrupt = 8'h00;
        tick();
        check("ack4_vector", o_vector, 8'h04);
        i_inta = 1'b0; i_interrupt = 8'h02;
        tick(); tick();
        check("nest1_intr", {7'd0, o_intr}, 8'h01);
        i_inta = 1'b1; i_interrupt = 8'h00;
        tick();
        check("ack1_vector", o_vector, 8'h01);
        i_inta = 1'b0; i_interrupt = 8'h08;
        tick(); tick(); tick();
        check("isr12_blocks3", {7'd0, o_intr}, 8'h00);
        wr(2'd1, 8'h00);
        tick();
        check("eoi1_unblocks3", {7'd0, o_intr}, 8'h01);

        // Reset while lines are in service.
        do_reset();
        i_interrupt = 8'h00;

        // AEOI leaves ISR empty so a lower line is not blocked.
        wr(2'd2, 8'hFF);
        wr(2'd3, 8'h03);
        i_interrupt = 8'h04;
        tick(); tick();
        i_inta = 1'b1; i_interrupt = 8'h00;
        tick();
        check("aeoi_vector", o_vector, 8'h02);
        i_inta = 1'b0; i_interrupt = 8'h08;
        tick(); tick();
        check("aeoi_intr", {7'd0, o_intr}, 8'h01);

        // Random traffic against the model.
        i_interrupt = 8'h00;
        do_reset();
        wr(2'd2, 8'hFF);
        wr(2'd3, 8'h01);
        for (int n = 0; n < 600; n++) begin
            i_interrupt = 8'($urandom) & 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 2) == 0) i_inta = ~i_inta;
            i_cs   = ($urandom_range(0, 5) == 0);
            i_we   = ($urandom_range(0, 1) == 0);
            i_addr = 2'($urandom);
            i_data = 8'($urandom);
            if (i_addr == 2'd3) i_data[0] = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
